// File: rtl/lab_iram_pkg.sv
// Shared types and helpers for the loadable lab instruction RAM.
package lab_iram_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } iram_state_t;

    localparam int MAX_WORD_W = 64;
    localparam logic [MAX_WORD_W-1:0] NOP_WORD = '0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/lab_iram_loader.sv
// Byte-stream loader: assembles little-endian bytes into words and issues array writes.
// Write is combinational on the accepting byte; stops at LD_LAST or the last word.
module lab_iram_loader
    import lab_iram_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 128,
    parameter int MEM_AW = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              active,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              wr_en,
    output logic [MEM_AW-1:0] wr_idx,
    output logic [WORD_W-1:0] wr_dat,
    output logic              done
);
    localparam int BPW    = WORD_W / 8;
    localparam int LANE_W = (BPW > 1) ? clog2(BPW) : 1;

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] asm_q;
    logic [MEM_AW-1:0] ptr_q;
    logic              accept;
    logic              last_lane;

    // A restart in the same cycle as a byte wins; the byte is dropped.
    assign accept    = active & ld_valid & ~ld_start;
    assign last_lane = (lane_q == LANE_W'(BPW - 1));
    assign wr_en     = accept & (last_lane | ld_last);
    assign wr_idx    = ptr_q;
    assign done      = wr_en & (ld_last | (ptr_q == MEM_AW'(DEPTH - 1)));

    always_comb begin
        wr_dat = asm_q;
        for (int l = 0; l < BPW; l++) begin
            if (lane_q == LANE_W'(l)) wr_dat[8*l +: 8] = ld_byte;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lane_q <= '0;
            asm_q  <= '0;
            ptr_q  <= '0;
        end else if (!active || ld_start) begin
            lane_q <= '0;
            asm_q  <= '0;
            ptr_q  <= '0;
        end else if (accept) begin
            if (wr_en) begin
                lane_q <= '0;
                asm_q  <= '0;
                ptr_q  <= ptr_q + 1'b1;
            end else begin
                lane_q <= lane_q + 1'b1;
                asm_q  <= wr_dat;
            end
        end
    end

endmodule

// File: rtl/lab_iram_loadable.sv
// Loadable instruction RAM: NOP sweep after reset, byte loader, 1-cycle registered fetch.
// Fetch returns NOP while BUSY; LD_READY only in LOAD. Optional parity with IRAM_PARITY_EN.
module lab_iram_loadable
    import lab_iram_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [WORD_W-1:0] Q,
    output logic              MISALIGN,
    output logic              BUSY,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [7:0]        LD_BYTE,
    input  logic              LD_LAST,
    output logic              LD_READY,
`ifdef IRAM_PARITY_EN
    input  logic              PAR_FLIP,
    output logic              PERR,
`endif
    output logic              LD_DONE
);
    localparam int BPW    = WORD_W / 8;
    localparam int OFF_W  = clog2(BPW);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    iram_state_t       state, state_nxt;
    logic [MEM_AW-1:0] clr_idx;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              ld_wr_en;
    logic [MEM_AW-1:0] ld_wr_idx;
    logic [WORD_W-1:0] ld_wr_dat;
    logic              ld_done_c;

    logic [IDX_W-1:0]  rd_idx;
    logic              rd_in_range;
    logic [WORD_W-1:0] rd_word;
    logic              mis_c;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == MEM_AW'(DEPTH - 1)) state_nxt = IDLE;
            IDLE:    if (LD_START) state_nxt = LOAD;
            LOAD:    if (ld_done_c) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)               clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    lab_iram_loader #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .MEM_AW (MEM_AW)
    ) u_loader (
        .CLK      (CLK),
        .RESET    (RESET),
        .active   (state == LOAD),
        .ld_start (LD_START),
        .ld_valid (LD_VALID),
        .ld_byte  (LD_BYTE),
        .ld_last  (LD_LAST),
        .wr_en    (ld_wr_en),
        .wr_idx   (ld_wr_idx),
        .wr_dat   (ld_wr_dat),
        .done     (ld_done_c)
    );

    // Array has no reset: contents are only defined by the clear sweep.
    always_ff @(posedge CLK) begin
        if (state == CLEAR)  mem[clr_idx]   <= NOP_WORD[WORD_W-1:0];
        else if (ld_wr_en)   mem[ld_wr_idx] <= ld_wr_dat;
    end

    always_comb begin
        rd_idx      = IDX_W'(ADDR >> OFF_W);
        rd_in_range = 32'(rd_idx) < DEPTH;
        rd_word     = mem[rd_idx[MEM_AW-1:0]];
    end

    if (OFF_W > 0) begin : g_mis
        assign mis_c = |ADDR[OFF_W-1:0];
    end else begin : g_nomis
        assign mis_c = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q        <= '0;
            MISALIGN <= 1'b0;
            LD_DONE  <= 1'b0;
        end else begin
            Q        <= (state == IDLE && rd_in_range) ? rd_word : NOP_WORD[WORD_W-1:0];
            MISALIGN <= mis_c;
            LD_DONE  <= (state == LOAD) & ld_done_c;
        end
    end

`ifdef IRAM_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge CLK) begin
        if (state == CLEAR) mem_par[clr_idx]   <= 1'b0;
        else if (ld_wr_en)  mem_par[ld_wr_idx] <= (^ld_wr_dat) ^ PAR_FLIP;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) PERR <= 1'b0;
        else       PERR <= (state == IDLE) && rd_in_range &&
                           ((^rd_word) != mem_par[rd_idx[MEM_AW-1:0]]);
    end
`endif

    assign BUSY     = (state != IDLE);
    assign LD_READY = (state == LOAD);

endmodule

// File: tb/tb_lab_iram_loadable.sv
// Scoreboard bench for lab_iram_loadable: a word-level program model predicts every fetch.
module tb_lab_iram_loadable;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 128;
    localparam int BPW    = WORD_W / 8;

    logic              CLK      = 1'b0;
    logic              RESET    = 1'b0;
    logic [ADDR_W-1:0] ADDR     = '0;
    logic [WORD_W-1:0] Q;
    logic              MISALIGN;
    logic              BUSY;
    logic              LD_START = 1'b0;
    logic              LD_VALID = 1'b0;
    logic [7:0]        LD_BYTE  = '0;
    logic              LD_LAST  = 1'b0;
    logic              LD_READY;
    logic              LD_DONE;
`ifdef IRAM_PARITY_EN
    logic              PAR_FLIP = 1'b0;
    logic              PERR;
`endif

    lab_iram_loadable #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDR     (ADDR),
        .Q        (Q),
        .MISALIGN (MISALIGN),
        .BUSY     (BUSY),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_BYTE  (LD_BYTE),
        .LD_LAST  (LD_LAST),
        .LD_READY (LD_READY),
`ifdef IRAM_PARITY_EN
        .PAR_FLIP (PAR_FLIP),
        .PERR     (PERR),
`endif
        .LD_DONE  (LD_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WORD_W-1:0] q;
        logic              mis;
        logic              perr;
    } rd_exp_t;

    int                n_checks = 0;
    int                n_pass   = 0;
    rd_exp_t           exp_q[$];
    logic [WORD_W-1:0] model_mem  [DEPTH];
    bit                model_flip [DEPTH];
    logic [7:0]        stream[$];
    logic              rd_fire  = 1'b0;
    int                done_cnt = 0;
    int                gap_max  = 0;
    int                flip_w   = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic rd_exp_t exp_read(input logic [ADDR_W-1:0] a, input bit idle);
        rd_exp_t e;
        int      idx;
        idx    = int'(a) / BPW;
        e.mis  = (int'(a) % BPW) != 0;
        e.q    = '0;
        e.perr = 1'b0;
        if (idle && idx < DEPTH) begin
            e.q    = model_mem[idx];
            e.perr = model_flip[idx];
        end
        return e;
    endfunction

    // Whole words from the stream are stored; a trailing partial word only when LD_LAST ends it.
    function automatic void model_stream(input bit last, input int nb);
        logic [WORD_W-1:0] v;
        int full;
        full = nb / BPW;
        for (int w = 0; w < full; w++) begin
            v = '0;
            for (int l = 0; l < BPW; l++) v[8*l +: 8] = stream[w*BPW + l];
            model_mem[w]  = v;
            model_flip[w] = (w == flip_w);
        end
        if (last && (nb % BPW) != 0) begin
            v = '0;
            for (int l = 0; l < nb % BPW; l++) v[8*l +: 8] = stream[full*BPW + l];
            model_mem[full]  = v;
            model_flip[full] = (full == flip_w);
        end
    endfunction

    // Monitor: pops one expectation for every edge at which a fetch was issued.
    initial begin
        logic    fire;
        rd_exp_t e;
        forever begin
            @(posedge CLK);
            fire = rd_fire;
            #1;
            if (LD_DONE) done_cnt++;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("rd_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_q", Q, e.q);
                    check("rd_misalign", MISALIGN, e.mis);
`ifdef IRAM_PARITY_EN
                    check("rd_perr", PERR, e.perr);
`endif
                end
            end
        end
    end

    task automatic rd(input logic [ADDR_W-1:0] a, input bit idle);
        @(negedge CLK);
        ADDR    = a;
        rd_fire = 1'b1;
        exp_q.push_back(exp_read(a, idle));
    endtask

    task automatic rd_end();
        @(negedge CLK);
        rd_fire = 1'b0;
    endtask

    task automatic reset_sweep();
        RESET    = 1'b1;
        rd_fire  = 1'b0;
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        #1;
        check("rst_busy", BUSY, 1);
        check("rst_q", Q, 0);
        check("rst_misalign", MISALIGN, 0);
        check("rst_ld_ready", LD_READY, 0);
        check("rst_ld_done", LD_DONE, 0);
        for (int w = 0; w < DEPTH; w++) begin
            model_mem[w]  = '0;
            model_flip[w] = 1'b0;
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            ADDR    = (k % 2 == 1) ? ADDR_W'(9'h010) : ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
            rd_fire = 1'b1;
            exp_q.push_back(exp_read(ADDR, 1'b0));
            @(posedge CLK);
            #1;
            check("busy_sweep", BUSY, k < DEPTH);
            @(negedge CLK);
        end
        rd_fire = 1'b0;
    endtask

    task automatic load(input bit last);
        int acc, d0, nb;
        bit comp;
        d0  = done_cnt;
        acc = 0;
        @(negedge CLK);
        LD_START = 1'b1;
        LD_VALID = 1'($urandom_range(0, 1));
        LD_BYTE  = 8'($urandom);
        @(negedge CLK);
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge CLK);
`ifdef IRAM_PARITY_EN
            PAR_FLIP = (i / BPW == flip_w);
`endif
            LD_VALID = 1'b1;
            LD_BYTE  = stream[i];
            LD_LAST  = last && (i == stream.size() - 1);
            if (LD_READY) acc++;
            @(negedge CLK);
            LD_VALID = 1'b0;
            LD_LAST  = 1'b0;
        end
`ifdef IRAM_PARITY_EN
        PAR_FLIP = 1'b0;
`endif
        nb   = (stream.size() < DEPTH * BPW) ? stream.size() : DEPTH * BPW;
        comp = last || (nb >= DEPTH * BPW);
        model_stream(last, nb);
        repeat (3) @(negedge CLK);
        check("ld_accepted", acc, nb);
        check("ld_done_pulses", done_cnt - d0, comp);
        if (comp) check("ld_ready_after_done", LD_READY, 0);
    endtask

    task automatic verify_all();
        for (int w = 0; w < DEPTH; w++)
            rd(ADDR_W'(w * BPW + $urandom_range(0, BPW - 1)), 1'b1);
        repeat (8) rd(ADDR_W'($urandom_range(0, 2**ADDR_W - 1)), 1'b1);
        rd(ADDR_W'(9'h100), 1'b1);
        rd_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        #2;
        reset_sweep();

        stream = '{8'h01, 8'hF0, 8'h7F, 8'h51};
        load(1'b1);
        rd(ADDR_W'(9'h002), 1'b1);
        rd(ADDR_W'(9'h000), 1'b1);
        rd_end();

        stream = '{8'hAA, 8'hBB, 8'hCC};
        load(1'b1);
        rd(ADDR_W'(9'h003), 1'b1);
        rd(ADDR_W'(9'h001), 1'b1);
        rd_end();

        for (int t = 0; t < 4; t++) begin
            gap_max = t;
            stream.delete();
            repeat ($urandom_range(1, 24)) stream.push_back(8'($urandom));
            load(1'b1);
            verify_all();
        end

        gap_max = 0;
        stream.delete();
        repeat (260) stream.push_back(8'($urandom));
        load(1'b0);
        verify_all();

        stream = '{8'h5A, 8'hA5, 8'h3C};
        load(1'b0);
        stream = '{8'h11, 8'h22};
        load(1'b1);
        verify_all();

`ifdef IRAM_PARITY_EN
        flip_w = 5;
        stream.delete();
        for (int i = 0; i < 10; i++) stream.push_back(8'($urandom));
        stream.push_back(8'h34);
        stream.push_back(8'h12);
        load(1'b1);
        rd(ADDR_W'(9'h00A), 1'b1);
        rd(ADDR_W'(9'h008), 1'b1);
        rd_end();
        verify_all();
        flip_w = -1;
`endif

        @(negedge CLK);
        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            LD_VALID = 1'b1;
            LD_BYTE  = 8'($urandom);
            @(negedge CLK);
        end
        #2;
        reset_sweep();
        verify_all();

        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
